digit_argmax: RTL and testbench



---
 rtl/digit_pkg.sv | 14 +
 rtl/argmax_tracker.sv | 78 +++++++
 rtl/flex_counter.sv | 22 ++
 rtl/digit_argmax.sv | 142 ++++++++++++++
 tb/tb_digit_argmax.sv | 200 ++++++++++++++++++++
 5 files changed

// File: rtl/digit_pkg.sv
// Shared digit-recognition definitions, used by the argmax scanner, the SPI
// output stage and the network controller.
package digit_pkg;
  localparam int DIGIT_W      = 4;   // width of a class index
  localparam int SIG_OUT_BASE = 8;   // sigmoid address of output neuron 0
  localparam int NUM_DIGITS   = 10;  // output-layer neuron count

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } argmax_state_t;
endpackage

// File: rtl/argmax_tracker.sv
// Running maximum tracker for the argmax scan. The next-state values are
// exported so the final sample can be folded into the result in one cycle.
// DIGIT_ARGMAX_MARGIN_EN adds runner-up tracking.
module argmax_tracker
  import digit_pkg::*;
#(
  parameter int DATA_W = 4
) (
  input  logic               clk,
  input  logic               n_rst,
  input  logic               clear,
  input  logic               sample_valid,
  input  logic [DATA_W-1:0]  data,
  input  logic [DIGIT_W-1:0] idx,
  output logic [DATA_W-1:0]  best_nxt,
  output logic [DIGIT_W-1:0] best_idx_nxt
`ifdef DIGIT_ARGMAX_MARGIN_EN
  ,
  output logic [DATA_W-1:0]  runner_nxt
`endif
);
  logic [DATA_W-1:0]  best_q;
  logic [DIGIT_W-1:0] best_idx_q;
  logic               first_q;
  logic               upd;
`ifdef DIGIT_ARGMAX_MARGIN_EN
  logic [DATA_W-1:0]  runner_q;
`endif

  // Strict compare keeps the lowest index on ties; first sample always wins.
  assign upd = sample_valid & (first_q | (data > best_q));

  // Next best / runner-up selection.
  always_comb begin
    best_nxt     = best_q;
    best_idx_nxt = best_idx_q;
`ifdef DIGIT_ARGMAX_MARGIN_EN
    runner_nxt   = runner_q;
`endif
    if (clear) begin
      best_nxt     = '0;
      best_idx_nxt = '0;
`ifdef DIGIT_ARGMAX_MARGIN_EN
      runner_nxt   = '0;
`endif
    end else if (upd) begin
      best_nxt     = data;
      best_idx_nxt = idx;
`ifdef DIGIT_ARGMAX_MARGIN_EN
      runner_nxt   = best_q;
`endif
    end
`ifdef DIGIT_ARGMAX_MARGIN_EN
    else if (sample_valid && (data > runner_q)) begin
      runner_nxt = data;
    end
`endif
  end

  // Tracker state registers.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      best_q     <= '0;
      best_idx_q <= '0;
      first_q    <= 1'b1;
`ifdef DIGIT_ARGMAX_MARGIN_EN
      runner_q   <= '0;
`endif
    end else begin
      best_q     <= best_nxt;
      best_idx_q <= best_idx_nxt;
      first_q    <= clear ? 1'b1 : (sample_valid ? 1'b0 : first_q);
`ifdef DIGIT_ARGMAX_MARGIN_EN
      runner_q   <= runner_nxt;
`endif
    end
  end
endmodule

// File: rtl/flex_counter.sv
// Enabled up-counter with synchronous clear that wraps to 0 after reaching
// rollover_val; rollover_flag marks the terminal count.
module flex_counter #(
  parameter int NUM_CNT_BITS = 4
) (
  input  logic                    clk,
  input  logic                    n_rst,
  input  logic                    clear,
  input  logic                    count_enable,
  input  logic [NUM_CNT_BITS-1:0] rollover_val,
  output logic [NUM_CNT_BITS-1:0] count_out,
  output logic                    rollover_flag
);
  // Count register: clear has priority, wrap on terminal count.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst)            count_out <= '0;
    else if (clear)        count_out <= '0;
    else if (count_enable) count_out <= (count_out == rollover_val) ? '0 : count_out + 1'b1;
  end

  assign rollover_flag = (count_out == rollover_val);
endmodule

// File: rtl/digit_argmax.sv
// Output-layer argmax: on a rising network_done, reads the output neurons
// from the sigmoid register file and presents the winning digit and its
// activation until acked. Optional DIGIT_ARGMAX_MARGIN_EN drives low_conf
// when the best-vs-runner-up margin is below MARGIN_MIN.
module digit_argmax
  import digit_pkg::*;
#(
  parameter int NUM_CLASSES = NUM_DIGITS,
  parameter int BASE_ADDR   = SIG_OUT_BASE,
  parameter int ADDR_W      = 5,
  parameter int DATA_W      = 4,
  parameter int MARGIN_MIN  = 2
) (
  input  logic               clk,
  input  logic               n_rst,
  input  logic               network_done,
  output logic [ADDR_W-1:0]  sig_rd_addr,
  output logic               sig_rd_en,
  input  logic [DATA_W-1:0]  sig_rd_data,
  output logic               busy,
  output logic [DIGIT_W-1:0] digit,
  output logic [DATA_W-1:0]  confidence,
  output logic               digit_valid,
  input  logic               ack,
  output logic               low_conf
);
  localparam int IDX_W = $clog2(NUM_CLASSES + 1);

  // Parameter legality: read addresses must not wrap.
  if ((BASE_ADDR + NUM_CLASSES > 2 ** ADDR_W) || (NUM_CLASSES < 1) ||
      (NUM_CLASSES > 16) || (MARGIN_MIN < 0)) begin : g_param_chk
    $error("digit_argmax: illegal parameters");
  end

  argmax_state_t      state, state_nxt;
  logic               done_q, start, last;
  logic [IDX_W-1:0]   idx;
  logic               rd_en_q;
  logic [DIGIT_W-1:0] idx_q;
  logic               trk_clear;
  logic [DATA_W-1:0]  best_nxt;
  logic [DIGIT_W-1:0] best_idx_nxt;

  assign start = network_done & ~done_q;

  // Edge detector; resets high so a level held through reset is not a start.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) done_q <= 1'b1;
    else        done_q <= network_done;
  end

  // State register.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic; start in DONE wins over a simultaneous ack.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = READ;
      READ:    if (last)  state_nxt = DRAIN;
      DRAIN:   state_nxt = DONE;
      DONE:    if (start) state_nxt = READ;
               else if (ack) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  flex_counter #(.NUM_CNT_BITS(IDX_W)) u_idx_cnt (
    .clk          (clk),
    .n_rst        (n_rst),
    .clear        (state != READ),
    .count_enable (state == READ),
    .rollover_val (IDX_W'(NUM_CLASSES - 1)),
    .count_out    (idx),
    .rollover_flag(last)
  );

  assign sig_rd_en   = (state == READ);
  assign sig_rd_addr = sig_rd_en ? (ADDR_W'(BASE_ADDR) + ADDR_W'(idx)) : '0;
  assign busy        = (state == READ) || (state == DRAIN);
  assign trk_clear   = (state == IDLE) || ((state == DONE) && start);

  // Pair each returning data word with the index that requested it.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      rd_en_q <= 1'b0;
      idx_q   <= '0;
    end else begin
      rd_en_q <= sig_rd_en;
      idx_q   <= DIGIT_W'(idx);
    end
  end

`ifdef DIGIT_ARGMAX_MARGIN_EN
  logic [DATA_W-1:0] runner_nxt;
  logic [DATA_W:0]   margin;
  assign margin = {1'b0, best_nxt} - {1'b0, runner_nxt};
`endif

  argmax_tracker #(.DATA_W(DATA_W)) u_trk (
    .clk         (clk),
    .n_rst       (n_rst),
    .clear       (trk_clear),
    .sample_valid(rd_en_q),
    .data        (sig_rd_data),
    .idx         (idx_q),
    .best_nxt    (best_nxt),
    .best_idx_nxt(best_idx_nxt)
`ifdef DIGIT_ARGMAX_MARGIN_EN
    ,
    .runner_nxt  (runner_nxt)
`endif
  );

  // Result registers: load as DRAIN folds in the last sample, drop valid on ack/restart.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      digit       <= '0;
      confidence  <= '0;
      digit_valid <= 1'b0;
    end else if (state == DRAIN) begin
      digit       <= best_idx_nxt;
      confidence  <= best_nxt;
      digit_valid <= 1'b1;
    end else if ((state == DONE) && (start || ack)) begin
      digit_valid <= 1'b0;
    end
  end

`ifdef DIGIT_ARGMAX_MARGIN_EN
  // Low-confidence flag registered alongside the digit.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst)                low_conf <= 1'b0;
    else if (state == DRAIN)   low_conf <= (margin < (DATA_W + 1)'(MARGIN_MIN));
  end
`else
  assign low_conf = 1'b0;
`endif
endmodule

// File: tb/tb_digit_argmax.sv
// Bench for digit_argmax: sigmoid register file model, directed and random
// scans checked against an array-level argmax/runner-up reference.
module tb_digit_argmax;
  localparam int N    = 10;
  localparam int BASE = 8;
  localparam int AW   = 5;
  localparam int DW   = 4;
  localparam int MM   = 2;

  logic          clk = 1'b0;
  logic          n_rst = 1'b0;
  logic          network_done = 1'b0;
  logic          ack = 1'b0;
  logic [AW-1:0] sig_rd_addr;
  logic          sig_rd_en;
  logic [DW-1:0] sig_rd_data = '0;
  logic          busy;
  logic [3:0]    digit;
  logic [DW-1:0] confidence;
  logic          digit_valid;
  logic          low_conf;

  logic [DW-1:0] mem [0:31];
  logic [DW-1:0] vals [N];
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  // Registered read port, 1-cycle latency.
  always @(posedge clk) if (sig_rd_en) sig_rd_data <= mem[sig_rd_addr];

  digit_argmax dut (
    .clk(clk), .n_rst(n_rst), .network_done(network_done),
    .sig_rd_addr(sig_rd_addr), .sig_rd_en(sig_rd_en), .sig_rd_data(sig_rd_data),
    .busy(busy), .digit(digit), .confidence(confidence),
    .digit_valid(digit_valid), .ack(ack), .low_conf(low_conf)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // Start a scan on a fresh network_done edge and check the full result.
  task automatic run_scan(input bit with_ack, input bit extra_edge);
    int lat, bi, sec;
    bit lc;
    logic [AW-1:0] ra [$];
    for (int i = 0; i < N; i++) mem[BASE+i] = vals[i];
    bi = 0;
    for (int i = 1; i < N; i++) if (vals[i] > vals[bi]) bi = i;
    sec = 0;
    for (int i = 0; i < N; i++) if (i != bi && int'(vals[i]) > sec) sec = vals[i];
`ifdef DIGIT_ARGMAX_MARGIN_EN
    lc = (int'(vals[bi]) - sec) < MM;
`else
    lc = 1'b0;
`endif
    @(posedge clk); #1;
    network_done = 1'b1;
    if (with_ack) ack = 1'b1;
    lat = 0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (k == 1) begin
        ack = 1'b0;
        chk("busy_start", busy, 1);
        chk("valid_low_in_scan", digit_valid, 0);
      end
      if (k == 2) network_done = 1'b0;
      if (extra_edge && k == 4) network_done = 1'b1;
      if (extra_edge && k == 6) network_done = 1'b0;
      if (sig_rd_en) ra.push_back(sig_rd_addr);
      if (digit_valid) begin lat = k; break; end
    end
    chk("latency", lat, N + 2);
    chk("num_reads", ra.size(), N);
    for (int i = 0; i < ra.size() && i < N; i++) chk("rd_addr", ra[i], BASE + i);
    chk("digit", digit, bi);
    chk("confidence", confidence, vals[bi]);
    chk("low_conf", low_conf, lc);
    chk("busy_done", busy, 0);
  endtask

  // Ack the held result, then confirm the block stays idle.
  task automatic do_ack();
    logic [3:0] d;
    logic [DW-1:0] c;
    int nb;
    d = digit; c = confidence;
    @(posedge clk); #1; ack = 1'b1;
    @(posedge clk); #1; ack = 1'b0;
    chk("ack_valid", digit_valid, 0);
    chk("ack_digit_kept", digit, d);
    chk("ack_conf_kept", confidence, c);
    nb = 0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      if (busy || sig_rd_en || digit_valid) nb++;
    end
    chk("idle_after_ack", nb, 0);
  endtask

  initial begin
    int bad;
    logic [3:0] d0;
    logic [DW-1:0] c0;
    // Reset, with network_done high through release.
    network_done = 1'b1;
    #2;
    chk("rst_busy", busy, 0);
    chk("rst_valid", digit_valid, 0);
    chk("rst_digit", digit, 0);
    chk("rst_conf", confidence, 0);
    chk("rst_rd_en", sig_rd_en, 0);
    chk("rst_rd_addr", sig_rd_addr, 0);
    chk("rst_low_conf", low_conf, 0);
    repeat (3) @(posedge clk);
    #1 n_rst = 1'b1;
    bad = 0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      if (busy || sig_rd_en || digit_valid) bad++;
    end
    chk("no_start_after_rst", bad, 0);
    network_done = 1'b0;

    // Directed values.
    vals = '{4'd1, 4'd3, 4'd9, 4'd2, 4'd0, 4'd4, 4'd5, 4'd7, 4'd8, 4'd6};
    run_scan(1'b0, 1'b0);
    d0 = digit; c0 = confidence; bad = 0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      if (!digit_valid || digit !== d0 || confidence !== c0 || busy) bad++;
    end
    chk("hold_20", bad, 0);
    do_ack();

    // Tie at neurons 3 and 7.
    vals = '{default: 4'd0};
    vals[3] = 4'd15; vals[7] = 4'd15;
    run_scan(1'b0, 1'b0);
    do_ack();

    // Margin cases.
    vals = '{4'd0, 4'd8, 4'd1, 4'd2, 4'd9, 4'd3, 4'd0, 4'd5, 4'd1, 4'd4};
    run_scan(1'b0, 1'b0);
    do_ack();
    vals = '{4'd0, 4'd6, 4'd1, 4'd2, 4'd9, 4'd3, 4'd0, 4'd5, 4'd1, 4'd4};
    run_scan(1'b0, 1'b0);

    // Restart in DONE together with ack.
    for (int i = 0; i < N; i++) vals[i] = DW'($urandom_range(0, 15));
    run_scan(1'b1, 1'b0);
    do_ack();

    // Extra edge during READ is ignored.
    for (int i = 0; i < N; i++) vals[i] = DW'($urandom_range(0, 15));
    run_scan(1'b0, 1'b1);
    do_ack();

    // Reset mid-scan with network_done held high.
    @(posedge clk); #1 network_done = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("mid_scan_busy", busy, 1);
    n_rst = 1'b0;
    #1;
    chk("mrst_busy", busy, 0);
    chk("mrst_valid", digit_valid, 0);
    chk("mrst_digit", digit, 0);
    chk("mrst_conf", confidence, 0);
    chk("mrst_rd_en", sig_rd_en, 0);
    chk("mrst_rd_addr", sig_rd_addr, 0);
    chk("mrst_low_conf", low_conf, 0);
    repeat (2) @(posedge clk);
    #1 n_rst = 1'b1;
    bad = 0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      if (busy || sig_rd_en || digit_valid) bad++;
    end
    chk("no_result_after_mrst", bad, 0);
    network_done = 1'b0;

    // Random scans, random ack/restart mix.
    for (int t = 0; t < 15; t++) begin
      for (int i = 0; i < N; i++) vals[i] = DW'($urandom_range(0, 15));
      run_scan(1'($urandom_range(0, 1)), 1'b0);
      if ($urandom_range(0, 1) == 1) do_ack();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
